axi_b_responder: RTL

Terminating write-side responder for the AXI slice library. It accepts write-address (AW) and write-data (W) traffic and sinks the data. For each burst it returns one write response (B) carrying the burst's ID and USER. The response is OKAY when WLAST lines up with the AW length, and SLVERR otherwise. It sits at the slave end of an AW/W/B channel set, typically behind the AW and W buffers, as an error slave or a write sink.

---
 rtl/axi_b_responder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axi_b_responder.sv
// axi_b_responder: terminating AW/W/B slave end.
// Sinks W beats and answers each burst with OKAY or SLVERR.
module axi_b_responder #(
  parameter int ID_WIDTH     = 4,
  parameter int USER_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic                  slave_aw_valid_i,
  input  logic [7:0]            slave_aw_len_i,
  input  logic [ID_WIDTH-1:0]   slave_aw_id_i,
  input  logic [USER_WIDTH-1:0] slave_aw_user_i,
  output logic                  slave_aw_ready_o,
  input  logic                  slave_w_valid_i,
  input  logic                  slave_w_last_i,
  output logic                  slave_w_ready_o,
  output logic                  slave_b_valid_o,
  output logic [ID_WIDTH-1:0]   slave_b_id_o,
  output logic [1:0]            slave_b_resp_o,
  output logic [USER_WIDTH-1:0] slave_b_user_o,
  input  logic                  slave_b_ready_i,
  output logic [15:0]           err_cnt_o
);

  localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUFFER_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [7:0]            len;
    logic [ID_WIDTH-1:0]   id;
    logic [USER_WIDTH-1:0] user;
  } aw_ent_t;

  aw_ent_t         r_mem [BUFFER_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  state_t          r_state;
  logic [7:0]      r_beat;
  logic            r_w_ready;
  logic            r_b_valid;
  logic [ID_WIDTH-1:0]   r_b_id;
  logic [USER_WIDTH-1:0] r_b_user;
  logic [1:0]      r_b_resp;
  logic [15:0]     r_err_cnt;

  aw_ent_t         w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_w_hs;
  logic            w_at_len;
  logic            w_final;
  logic            w_has_next;
  logic            w_unused_test_en;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_unused_test_en = test_en_i;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = slave_aw_valid_i && !w_full;
  assign w_w_hs     = slave_w_valid_i && r_w_ready;
  assign w_at_len   = (r_beat == w_head.len);
  assign w_final    = w_w_hs && (w_at_len || slave_w_last_i);
  assign w_has_next = !w_empty || w_push;

  assign slave_aw_ready_o = !w_full;
  assign slave_w_ready_o  = r_w_ready;
  assign slave_b_valid_o  = r_b_valid;
  assign slave_b_id_o     = r_b_id;
  assign slave_b_resp_o   = r_b_resp;
  assign slave_b_user_o   = r_b_user;
  assign err_cnt_o        = r_err_cnt;

  // AW entry storage; contents are only meaningful while counted
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{
        len:  slave_aw_len_i,
        id:   slave_aw_id_i,
        user: slave_aw_user_i
      };
    end
  end

  // AW FIFO pointers and occupancy; head pops on its final W beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_final) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_push && !w_final) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_final) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Burst FSM: count beats, close burst, hold B until accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_w_ready <= 1'b0;
      r_b_valid <= 1'b0;
      r_b_id    <= '0;
      r_b_user  <= '0;
      r_b_resp  <= RESP_OKAY;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          if (!w_empty) begin
            r_state   <= S_DATA;
            r_w_ready <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_w_hs) begin
            r_beat <= r_beat + 8'd1;
            if (w_final) begin
              r_state   <= S_RESP;
              r_w_ready <= 1'b0;
              r_b_valid <= 1'b1;
              r_b_id    <= w_head.id;
              r_b_user  <= w_head.user;
              r_b_resp  <= (w_at_len && slave_w_last_i) ?
                           RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        S_RESP: begin
          if (slave_b_ready_i) begin
            r_b_valid <= 1'b0;
            r_beat    <= '0;
            if (w_has_next) begin
              r_state   <= S_DATA;
              r_w_ready <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_w_ready <= 1'b0;
          r_b_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of SLVERR responses accepted on B
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if (r_b_valid && slave_b_ready_i &&
                 (r_b_resp == RESP_SLVERR) &&
                 (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

endmodule
